// File: rtl/cu_command_arbiter_rr_if.sv
// Command line / status types and the bus bundle between the command producers,
// the round-robin arbiter and the downstream command buffer.
package cu_cmd_arb_pkg;
  typedef struct packed {
    logic [3:0] cu_id;
    logic [7:0] real_size;
  } cmd_info_t;

  // valid is the MSB so the remaining bits form the stored payload
  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [7:0]  size;
    cmd_info_t   cmd;
    logic [3:0]  abt;
  } CommandBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
  } BufferStatus;
endpackage

interface cu_command_arbiter_rr_if
  import cu_cmd_arb_pkg::*;
#(
  parameter int NUM_REQUESTORS = 3
) ();
  localparam int GW = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1;

  CommandBufferLine [NUM_REQUESTORS-1:0] command_in;
  BufferStatus                           command_buffer_status_in;
  CommandBufferLine                      command_out;
  logic [NUM_REQUESTORS-1:0]             requestor_alfull_out;
  logic [NUM_REQUESTORS-1:0]             requestor_empty_out;
  logic [GW-1:0]                         grant_id_out;
  logic [NUM_REQUESTORS-1:0]             overflow_error_out;

  modport master (
    output command_in, command_buffer_status_in,
    input  command_out, requestor_alfull_out, requestor_empty_out,
           grant_id_out, overflow_error_out
  );

  modport slave (
    input  command_in, command_buffer_status_in,
    output command_out, requestor_alfull_out, requestor_empty_out,
           grant_id_out, overflow_error_out
  );
endinterface

// File: rtl/cu_command_arbiter_rr.sv
// Per-requestor command FIFOs feeding one downstream buffer through a
// round-robin grant; issue stalls on downstream almost-full or when disabled.
module cu_cmd_arb_fifo #(
  parameter int DEPTH  = 8,
  parameter int MARGIN = 3,
  parameter int W      = 56
) (
  input  logic         clock,
  input  logic         rstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         alfull_o,
  output logic         ovf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, wr_en;

  assign full    = (cnt_q == CW'(DEPTH));
  // a pop in the same cycle frees the slot the push needs
  assign wr_en   = push_i & (~full | pop_i);
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en & ~pop_i)      cnt_d = cnt_q + CW'(1);
    else if (pop_i & ~wr_en) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      empty_o  <= 1'b1;
      alfull_o <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + PW'(1);
      if (pop_i) rd_q <= rd_q + PW'(1);
      cnt_q    <= cnt_d;
      empty_o  <= (cnt_d == '0);
      alfull_o <= (cnt_d >= CW'(DEPTH - MARGIN));
      if (push_i & full & ~pop_i) ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_q] <= wdata_i;
  end
endmodule

module cu_command_arbiter_rr
  import cu_cmd_arb_pkg::*;
#(
  parameter int NUM_REQUESTORS = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int ALFULL_MARGIN  = 3
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enabled_in,
  cu_command_arbiter_rr_if.slave    bus
);
  localparam int N   = NUM_REQUESTORS;
  localparam int GW  = (N > 1) ? $clog2(N) : 1;
  localparam int PLW = $bits(CommandBufferLine) - 1;

  logic                       enabled_q;
  CommandBufferLine [N-1:0]   cin_q;
  logic [N-1:0][PLW-1:0]      head;
  logic [N-1:0]               empty, pop;
  logic                       issue;
  logic [GW-1:0]              win, idx, rr_d, rr_q, grant_q;
  CommandBufferLine           out_q;
  logic                       unused_status;

  assign unused_status = bus.command_buffer_status_in.full;

  // while disabled the staged payload is kept but cannot push again
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q <= 1'b0;
      cin_q     <= '0;
    end else begin
      enabled_q <= enabled_in;
      for (int i = 0; i < N; i++) begin
        if (enabled_q) cin_q[i]       <= bus.command_in[i];
        else           cin_q[i].valid <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_req
    cu_cmd_arb_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .MARGIN (ALFULL_MARGIN),
      .W      (PLW)
    ) u_fifo (
      .clock    (clock),
      .rstn     (rstn),
      .push_i   (cin_q[gi].valid),
      .pop_i    (pop[gi]),
      .wdata_i  (cin_q[gi][PLW-1:0]),
      .rdata_o  (head[gi]),
      .empty_o  (empty[gi]),
      .alfull_o (bus.requestor_alfull_out[gi]),
      .ovf_o    (bus.overflow_error_out[gi])
    );
  end

  // first non-empty FIFO at or above rr_q, wrapping
  always_comb begin
    issue = 1'b0;
    win   = '0;
    idx   = '0;
    pop   = '0;
    if (enabled_q && !bus.command_buffer_status_in.alfull) begin
      for (int k = 0; k < N; k++) begin
        idx = GW'((int'(rr_q) + k) % N);
        if (!issue && !empty[idx]) begin
          issue = 1'b1;
          win   = idx;
        end
      end
    end
    if (issue) pop[win] = 1'b1;
    rr_d = (win == GW'(N - 1)) ? '0 : win + GW'(1);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      out_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
    end else if (issue) begin
      out_q   <= {1'b1, head[win]};
      grant_q <= win;
      rr_q    <= rr_d;
    end else begin
      out_q   <= '0;
    end
  end

  assign bus.command_out         = out_q;
  assign bus.grant_id_out        = grant_q;
  assign bus.requestor_empty_out = empty;
endmodule

// File: tb/tb_cu_command_arbiter_rr.sv
// Bench for cu_command_arbiter_rr: directed table, multi-cycle corner sequences
// and random traffic, all checked against a queue-based reference model.
module tb_cu_command_arbiter_rr;
  import cu_cmd_arb_pkg::*;

  localparam int N = 3;
  localparam int D = 8;
  localparam int M = 3;

  logic clock = 1'b0;
  logic rstn = 1'b1;
  logic enabled_in = 1'b0;
  always #5 clock = ~clock;

  cu_command_arbiter_rr_if #(.NUM_REQUESTORS(N)) bus ();

  cu_command_arbiter_rr #(
    .NUM_REQUESTORS (N),
    .FIFO_DEPTH     (D),
    .ALFULL_MARGIN  (M)
  ) dut (
    .clock      (clock),
    .rstn       (rstn),
    .enabled_in (enabled_in),
    .bus        (bus)
  );

  // reference model: one queue per requestor plus the staging register
  CommandBufferLine mq [N][$];
  CommandBufferLine m_lat [N];
  CommandBufferLine m_out;
  bit               m_en;
  int               m_rr, m_grant;
  logic [N-1:0]     m_ovf;

  int n_checks = 0;
  int n_err = 0;
  int issued;
  int glog [$];
  logic [31:0] last_addr;

  typedef struct {
    logic [N-1:0] push;
    logic [31:0]  base;
    logic         exp_v;
    logic [31:0]  exp_addr;
    logic [1:0]   exp_g;
    logic [N-1:0] exp_empty;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_lat[i] = '0;
    end
    m_out = '0; m_en = 1'b0; m_rr = 0; m_grant = 0; m_ovf = '0;
  endfunction

  function automatic void model_step();
    int w = -1;
    if (m_en && !bus.command_buffer_status_in.alfull)
      for (int k = 0; k < N; k++)
        if (w < 0 && mq[(m_rr + k) % N].size() > 0) w = (m_rr + k) % N;
    if (w >= 0) begin
      m_out = mq[w].pop_front();
      m_grant = w;
      m_rr = (w + 1) % N;
    end else begin
      m_out = '0;
    end
    for (int i = 0; i < N; i++)
      if (m_lat[i].valid) begin
        if (mq[i].size() < D) mq[i].push_back(m_lat[i]);
        else m_ovf[i] = 1'b1;
      end
    for (int i = 0; i < N; i++)
      if (m_en) m_lat[i] = bus.command_in[i];
      else m_lat[i].valid = 1'b0;
    m_en = enabled_in;
  endfunction

  task automatic tick();
    logic [N-1:0] ee, ea;
    if (!rstn) model_reset();
    else model_step();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      ee[i] = (mq[i].size() == 0);
      ea[i] = (mq[i].size() >= D - M);
    end
    chk("cmd_out", 64'(bus.command_out), 64'(m_out));
    chk("flags", 64'({bus.grant_id_out, bus.requestor_empty_out, bus.requestor_alfull_out,
                      bus.overflow_error_out}),
                 64'({2'(m_grant), ee, ea, m_ovf}));
    if (bus.command_out.valid) begin
      issued++;
      glog.push_back(int'(bus.grant_id_out));
      last_addr = bus.command_out.address;
    end
  endtask

  function automatic CommandBufferLine mk(input int i, input logic [31:0] base);
    CommandBufferLine c;
    c.valid         = 1'b1;
    c.address       = base + 32'(i) * 32'h1000;
    c.size          = base[7:0] + 8'(i);
    c.cmd.cu_id     = 4'(i);
    c.cmd.real_size = base[15:8];
    c.abt           = 4'(i + 1);
    return c;
  endfunction

  task automatic drive(input logic [N-1:0] mask, input logic [31:0] base);
    for (int i = 0; i < N; i++)
      bus.command_in[i] = mask[i] ? mk(i, base) : '0;
  endtask

  task automatic check_reset_vals();
    chk("rst_cmd_out", 64'(bus.command_out), 64'd0);
    chk("rst_grant", 64'(bus.grant_id_out), 64'd0);
    chk("rst_ovf", 64'(bus.overflow_error_out), 64'd0);
    chk("rst_alfull", 64'(bus.requestor_alfull_out), 64'd0);
    chk("rst_empty", 64'(bus.requestor_empty_out), 64'b111);
  endtask

  task automatic do_reset();
    drive('0, '0);
    bus.command_buffer_status_in = '0;
    enabled_in = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    rstn = 1'b1;
    enabled_in = 1'b1;
    tick();
    issued = 0;
    glog.delete();
  endtask

  initial begin
    int bad;
    tbl[0] = '{3'b010, 32'h0,     1'b0, 32'h0,     2'd0, 3'b111};
    tbl[1] = '{3'b000, 32'h0,     1'b0, 32'h0,     2'd0, 3'b101};
    tbl[2] = '{3'b000, 32'h0,     1'b1, 32'h1000,  2'd1, 3'b111};
    tbl[3] = '{3'b000, 32'h0,     1'b0, 32'h0,     2'd1, 3'b111};
    tbl[4] = '{3'b101, 32'h20000, 1'b0, 32'h0,     2'd1, 3'b111};
    tbl[5] = '{3'b000, 32'h0,     1'b0, 32'h0,     2'd1, 3'b010};
    tbl[6] = '{3'b000, 32'h0,     1'b1, 32'h22000, 2'd2, 3'b110};
    tbl[7] = '{3'b000, 32'h0,     1'b1, 32'h20000, 2'd0, 3'b111};
    tbl[8] = '{3'b000, 32'h0,     1'b0, 32'h0,     2'd0, 3'b111};

    #2;
    do_reset();

    // latency and wrap-around grant order
    for (int r = 0; r < 9; r++) begin
      drive(tbl[r].push, tbl[r].base);
      tick();
      chk("tbl_valid", 64'(bus.command_out.valid), 64'(tbl[r].exp_v));
      if (tbl[r].exp_v)
        chk("tbl_addr", 64'(bus.command_out.address), 64'(tbl[r].exp_addr));
      chk("tbl_grant", 64'(bus.grant_id_out), 64'(tbl[r].exp_g));
      chk("tbl_empty", 64'(bus.requestor_empty_out), 64'(tbl[r].exp_empty));
    end

    // all requestors push six times
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(3'b111, 32'h80000 + 32'(k) * 32'h10);
      tick();
    end
    drive('0, '0);
    repeat (20) tick();
    chk("all_issued", 64'(issued), 64'd18);
    bad = 0;
    for (int k = 0; k < glog.size(); k++) if (glog[k] != k % 3) bad++;
    chk("all_rr_seq", 64'(bad), 64'd0);
    chk("all_ovf", 64'(bus.overflow_error_out), 64'd0);

    // overflow while downstream is almost full
    do_reset();
    bus.command_buffer_status_in.alfull = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(3'b001, 32'h30000 + 32'(k));
      tick();
    end
    drive('0, '0);
    repeat (2) tick();
    chk("ovf_set", 64'(bus.overflow_error_out), 64'b001);
    chk("ovf_alfull", 64'(bus.requestor_alfull_out), 64'b001);
    bus.command_buffer_status_in.alfull = 1'b0;
    issued = 0;
    repeat (12) tick();
    chk("ovf_drain_cnt", 64'(issued), 64'd8);

    // push and pop on a full FIFO in the same cycle
    do_reset();
    bus.command_buffer_status_in.alfull = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(3'b100, 32'h40000 + 32'(k));
      tick();
    end
    drive('0, '0);
    repeat (2) tick();
    drive(3'b100, 32'h50000);
    tick();
    drive('0, '0);
    bus.command_buffer_status_in.alfull = 1'b0;
    tick();
    bus.command_buffer_status_in.alfull = 1'b1;
    tick();
    chk("full_pp_ovf", 64'(bus.overflow_error_out), 64'd0);
    bus.command_buffer_status_in.alfull = 1'b0;
    issued = 0;
    repeat (10) tick();
    chk("full_pp_cnt", 64'(issued), 64'd8);
    chk("full_pp_last", 64'(last_addr), 64'h52000);

    // asynchronous reset with entries buffered
    do_reset();
    bus.command_buffer_status_in.alfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(3'b010, 32'h90000 + 32'(k));
      tick();
    end
    drive('0, '0);
    repeat (2) tick();
    #3;
    rstn = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge clock);
    #1;
    rstn = 1'b1;
    bus.command_buffer_status_in.alfull = 1'b0;
    issued = 0;
    repeat (5) tick();
    chk("post_rst_issued", 64'(issued), 64'd0);

    // disable with entries buffered, rr pointer must survive
    do_reset();
    drive(3'b001, 32'h60000);
    tick();
    drive('0, '0);
    repeat (2) tick();
    bus.command_buffer_status_in.alfull = 1'b1;
    drive(3'b111, 32'h70000);
    tick();
    drive('0, '0);
    repeat (2) tick();
    enabled_in = 1'b0;
    tick();
    bus.command_buffer_status_in.alfull = 1'b0;
    issued = 0;
    repeat (4) tick();
    chk("dis_issued", 64'(issued), 64'd0);
    enabled_in = 1'b1;
    glog.delete();
    repeat (6) tick();
    chk("reen_cnt", 64'(glog.size()), 64'd3);
    if (glog.size() == 3)
      chk("reen_order", 64'(glog[0] * 100 + glog[1] * 10 + glog[2]), 64'd120);

    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 40) begin
          bus.command_in[i] = CommandBufferLine'(57'({$urandom, $urandom}));
          bus.command_in[i].valid = 1'b1;
        end else begin
          bus.command_in[i] = '0;
        end
      end
      bus.command_buffer_status_in.alfull = ($urandom_range(0, 3) == 0);
      enabled_in = ($urandom_range(0, 19) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/cu_command_arbiter_rr.md
Name: cu_command_arbiter_rr

Overview:
- Shares one downstream command buffer between NUM_REQUESTORS command producers inside a compute unit, e.g. the read-data engine, the prefetch path and the write engine.
- Producers emit single-cycle valid CommandBufferLine pulses and do no handshake beyond watching an almost-full status.
- The block buffers each producer in a private FIFO and issues at most one command per cycle using round-robin grant.
- Issue stalls while the downstream buffer reports almost-full.

Parameters:
- NUM_REQUESTORS, 3, number of command producers; index 0 is the lowest.
- FIFO_DEPTH, 8, entries per requestor FIFO; power of two, at least 4.
- ALFULL_MARGIN, 3, free-entry margin at which a requestor's almost-full flag asserts.

Ports:
- clock  in  1  — core clock
- rstn  in  1  — asynchronous active-low reset
- enabled_in  in  1  — global enable; registered internally into `enabled`
- command_in  in  [NUM_REQUESTORS] x CommandBufferLine  — per-requestor command; a push occurs when .valid=1
- command_buffer_status_in  in  BufferStatus  — downstream buffer status; only .alfull is used
- command_out  out  CommandBufferLine  — granted command; .valid is a one-cycle pulse
- requestor_alfull_out  out  NUM_REQUESTORS  — per-FIFO almost-full, fed back to each producer
- requestor_empty_out  out  NUM_REQUESTORS  — per-FIFO empty
- grant_id_out  out  $clog2(NUM_REQUESTORS)  — index of the last issued requestor
- overflow_error_out  out  NUM_REQUESTORS  — sticky; a push arrived while that FIFO was full

Behaviour:
- Reset values (async, rstn=0):
  - command_out=0, grant_id_out=0, overflow_error_out=0
  - requestor_alfull_out=0, requestor_empty_out=all ones
  - all FIFO counts and pointers=0, `enabled`=0, round-robin pointer=0
- Reset mid-operation discards all buffered commands immediately. Nothing is issued until rstn is high and `enabled` is 1.
- Input staging:
  - command_in is registered once (command_in_latched) whenever `enabled`=1.
  - A push into FIFO i happens on the edge after command_in_latched[i].valid=1.
- FIFO i:
  - count width is $clog2(FIFO_DEPTH)+1.
  - A simultaneous push and pop in the same cycle leaves count unchanged, and both operations complete.
  - Push when count==FIFO_DEPTH with no pop in that cycle: the command is dropped, count is held, overflow_error_out[i] is set and stays set until reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Flags, registered from the next-state count:
  - requestor_alfull_out[i]=1 when count >= FIFO_DEPTH-ALFULL_MARGIN.
  - requestor_empty_out[i]=1 when count==0.
- Issue condition per cycle: `enabled`=1 AND command_buffer_status_in.alfull=0 AND at least one FIFO non-empty.
- Grant selection:
  - Scan from index rr_ptr upward, wrapping modulo NUM_REQUESTORS; the first non-empty FIFO wins.
  - The winner's head is popped and registered onto command_out with valid=1, all other fields unchanged.
  - grant_id_out is set to the winner; rr_ptr becomes (winner+1) mod NUM_REQUESTORS.
- When the issue condition is false: command_out=0 on the next edge, rr_ptr is held, grant_id_out is held.
- Latency:
  - Minimum 3 edges from command_in valid to command_out valid: input latch, FIFO write, grant register.
  - Throughput is 1 command per cycle aggregate.
- With `enabled`=0:
  - command_in_latched is held, so no new pushes occur.
  - Issue stalls, buffered entries are retained, command_out=0.
- Alfull assertion on command_buffer_status_in gates issue in the same cycle it is sampled. There is no partial issue.
- The command payload (address, size, cmd.cu_id, cmd.real_size, abt) passes through untouched. The arbiter never modifies or re-orders commands within one requestor.

Test Plan:
- Reset, then one push on requestor 1 with address 0x1000 → command_out.valid=1 exactly 3 edges later, address 0x1000, grant_id_out=1, requestor_empty_out returns to 3'b111.
- All three requestors push every cycle for 6 cycles, downstream never alfull → grants follow 0,1,2,0,1,2…; per-requestor order is preserved; 18 issues total; no overflow.
- Requestor 0 pushes 8 commands while downstream alfull=1 → requestor_alfull_out[0] asserts after count reaches 5; a 9th push sets overflow_error_out[0]=1 with count held at 8. Release alfull → exactly 8 commands issue.
- Requestor 2 FIFO at count 8, with a push and an issue in the same cycle → count stays 8, no overflow, and the new entry is issued after the 7 older ones.
- Assert rstn=0 while 5 entries are buffered → all outputs return to reset values asynchronously, and no command issues after reset release until a new push.
- Drop enabled_in for 4 cycles with 3 entries buffered → command_out stays 0 and rr_ptr is frozen; on re-enable the buffered entries issue starting from the saved rr_ptr.
